// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - receive-side PWM carrier decoder (period, high time, edges, stuck, overflow)
//
// Purpose: samples an asynchronous PWM pin, filters it, and measures per carrier
// period (framed by period_start_i) the cycle count, filtered high count and
// filtered rising-edge count. Also flags a gate stuck high/low and a sticky
// accumulator overflow.
//
// Ports:
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   enable_i          decoder enable (0 forces IDLE)
//   period_start_i    single-cycle carrier boundary strobe
//   pwm_i             asynchronous PWM pin
//   clear_i           clears overflow_o
//   period_count_o    cycles in the last complete period
//   high_count_o      filtered-high cycles in the last complete period
//   edges_o           filtered rising edges in the last period (saturating)
//   valid_o           1-cycle pulse after the outputs above update
//   stuck_high_o      edgeless for STUCK_PERIODS reports, level high
//   stuck_low_o       edgeless for STUCK_PERIODS reports, level low
//   overflow_o        sticky period accumulator saturation
module pwm_duty_decoder #(
  parameter int WIDTH         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_LEN    = 3,
  parameter int STUCK_PERIODS = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic             period_start_i,
  input  logic             pwm_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] period_count_o,
  output logic [WIDTH-1:0] high_count_o,
  output logic [3:0]       edges_o,
  output logic             valid_o,
  output logic             stuck_high_o,
  output logic             stuck_low_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] L_MAX = {WIDTH{1'b1}};
  localparam int FW = (FILTER_LEN < 1) ? 1 : $clog2(FILTER_LEN + 1);
  localparam int SW = (STUCK_PERIODS < 1) ? 1 : $clog2(STUCK_PERIODS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_seed;
  logic             w_report;
  logic             w_accum;

  logic [SYNC_STAGES-1:0] r_sync;
  logic             w_pwm_s;
  logic             w_pwm_f;
  logic             r_pwm_f_d;
  logic             w_rise;

  logic [WIDTH-1:0] r_per;
  logic [WIDTH-1:0] r_hi;
  logic [3:0]       r_edges;
  logic [SW-1:0]    r_stuck_cnt;
  logic             w_stuck;

  // Metastability chain; pwm_s is pwm_i delayed by SYNC_STAGES flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_i};
    end
  end
  assign w_pwm_s = r_sync[SYNC_STAGES-1];

  // Glitch filter: the level changes only after FILTER_LEN consecutive
  // disagreeing samples, so rise and fall see the same latency.
  generate
    if (FILTER_LEN == 0) begin : g_nofilt
      assign w_pwm_f = w_pwm_s;
    end else begin : g_filt
      logic          r_pwm_f;
      logic [FW-1:0] r_run;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          r_pwm_f <= 1'b0;
          r_run   <= '0;
        end else if (w_pwm_s == r_pwm_f) begin
          r_run <= '0;
        end else if (r_run == FW'(FILTER_LEN - 1)) begin
          r_pwm_f <= w_pwm_s;
          r_run   <= '0;
        end else begin
          r_run <= r_run + FW'(1);
        end
      end
      assign w_pwm_f = r_pwm_f;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pwm_f_d <= 1'b0;
    end else begin
      r_pwm_f_d <= w_pwm_f;
    end
  end
  assign w_rise = w_pwm_f & ~r_pwm_f_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_seed   = 1'b0;
    w_report = 1'b0;
    w_accum  = 1'b0;
    if (!enable_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_next = S_ARM;
        S_ARM: begin
          if (period_start_i) begin
            w_next = S_MEAS;
            w_seed = 1'b1;
          end
        end
        S_MEAS: begin
          if (period_start_i) begin
            w_seed   = 1'b1;
            w_report = 1'b1;
          end else begin
            w_accum = 1'b1;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Accumulators: seeded with the start cycle itself, zero outside a measurement.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_per   <= '0;
      r_hi    <= '0;
      r_edges <= '0;
    end else if (w_seed) begin
      r_per   <= WIDTH'(1);
      r_hi    <= WIDTH'(w_pwm_f);
      r_edges <= 4'(w_rise);
    end else if (w_accum) begin
      r_per   <= (r_per == L_MAX) ? r_per : r_per + WIDTH'(1);
      r_hi    <= (r_hi == L_MAX) ? r_hi : r_hi + WIDTH'(w_pwm_f);
      r_edges <= (r_edges == 4'd15) ? r_edges : r_edges + 4'(w_rise);
    end else begin
      r_per   <= '0;
      r_hi    <= '0;
      r_edges <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      period_count_o <= '0;
      high_count_o   <= '0;
      edges_o        <= '0;
      valid_o        <= 1'b0;
    end else begin
      valid_o <= w_report;
      if (w_report) begin
        period_count_o <= r_per;
        high_count_o   <= r_hi;
        edges_o        <= r_edges;
      end
    end
  end

  // Set has priority over clear while the period accumulator is pinned.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow_o <= 1'b0;
    end else if (w_accum && (r_per == L_MAX)) begin
      overflow_o <= 1'b1;
    end else if (clear_i) begin
      overflow_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stuck_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_stuck_cnt <= '0;
    end else if (w_report) begin
      if (r_edges != 4'd0) begin
        r_stuck_cnt <= '0;
      end else if (r_stuck_cnt != SW'(STUCK_PERIODS)) begin
        r_stuck_cnt <= r_stuck_cnt + SW'(1);
      end
    end
  end

  // Flags follow the live filtered level once the edgeless count is reached.
  assign w_stuck      = (r_stuck_cnt == SW'(STUCK_PERIODS));
  assign stuck_high_o = w_stuck & w_pwm_f;
  assign stuck_low_o  = w_stuck & ~w_pwm_f;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - directed scoreboard bench for pwm_duty_decoder
module tb_pwm_duty_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        start;
  logic        pwm;
  logic        clear;
  logic [15:0] per_o;
  logic [15:0] hi_o;
  logic [3:0]  edg_o;
  logic        valid;
  logic        sh;
  logic        sl;
  logic        ovf;

  typedef struct {
    logic [15:0] per;
    logic [15:0] hi;
    logic [3:0]  edg;
    logic        sh;
    logic        sl;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  pwm_duty_decoder #(
    .WIDTH(16), .SYNC_STAGES(2), .FILTER_LEN(3), .STUCK_PERIODS(4)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .enable_i       (enable),
    .period_start_i (start),
    .pwm_i          (pwm),
    .clear_i        (clear),
    .period_count_o (per_o),
    .high_count_o   (hi_o),
    .edges_o        (edg_o),
    .valid_o        (valid),
    .stuck_high_o   (sh),
    .stuck_low_o    (sl),
    .overflow_o     (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge. Any valid pulse
  // must match the oldest outstanding expected report.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("valid_without_expected_report", valid, 0);
      end else begin
        e = sb.pop_front();
        check("period_count", per_o, e.per);
        check("high_count", hi_o, e.hi);
        check("edges", edg_o, e.edg);
        check("stuck_high", sh, e.sh);
        check("stuck_low", sl, e.sl);
        check("high_le_period", (hi_o <= per_o), 1);
      end
    end
  endtask

  // Drives one carrier period. The expected report for this period is queued
  // after its start cycle so it can only be matched at the following start.
  task automatic run_period(input int len, input int hi_len, input int g_at, input int g_len,
                            input int dis_at, input int clr_from, input bit push,
                            input logic [15:0] e_hi, input logic [3:0] e_edg,
                            input bit e_sh, input bit e_sl);
    exp_t e;
    for (int c = 0; c < len; c++) begin
      start  = (c == 0);
      pwm    = (c < hi_len) || (c >= g_at && c < g_at + g_len);
      enable = !(dis_at >= 0 && c >= dis_at && c < dis_at + 5);
      clear  = (clr_from >= 0 && c >= clr_from);
      tick();
      if (c == 0 && push) begin
        e.per = (len > 65535) ? 16'hFFFF : 16'(len);
        e.hi  = e_hi;
        e.edg = e_edg;
        e.sh  = e_sh;
        e.sl  = e_sl;
        sb.push_back(e);
      end
    end
    start = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    start  = 1'b0;
    pwm    = 1'b0;
    clear  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_period", per_o, 0);
    check("reset_high", hi_o, 0);
    check("reset_edges", edg_o, 0);
    check("reset_valid", valid, 0);
    check("reset_stuck", {sh, sl}, 0);
    check("reset_overflow", ovf, 0);

    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (5) tick();

    // Basic 250/100 carrier.
    repeat (4) run_period(250, 100, -1, 0, -1, -1, 1, 16'd100, 4'd1, 0, 0);

    // Filtered and passed glitches in the low phase.
    run_period(250, 100, 150, 2, -1, -1, 1, 16'd100, 4'd1, 0, 0);
    run_period(250, 100, 150, 3, -1, -1, 1, 16'd103, 4'd2, 0, 0);

    // Pin held high for six periods, then normal carrier resumes.
    run_period(250, 250, -1, 0, -1, -1, 1, 16'd245, 4'd1, 0, 0);
    run_period(250, 250, -1, 0, -1, -1, 1, 16'd250, 4'd0, 0, 0);
    run_period(250, 250, -1, 0, -1, -1, 1, 16'd250, 4'd0, 0, 0);
    run_period(250, 250, -1, 0, -1, -1, 1, 16'd250, 4'd0, 0, 0);
    run_period(250, 250, -1, 0, -1, -1, 1, 16'd250, 4'd0, 1, 0);
    run_period(250, 250, -1, 0, -1, -1, 1, 16'd250, 4'd0, 1, 0);
    run_period(250, 100, -1, 0, -1, -1, 1, 16'd105, 4'd0, 0, 1);
    run_period(250, 100, -1, 0, -1, -1, 1, 16'd100, 4'd1, 0, 0);

    // Enable dropped mid-period: partial period is never reported and the
    // next start only re-arms.
    run_period(250, 100, -1, 0, 120, -1, 0, 16'd0, 4'd0, 0, 0);
    check("no_overflow_yet", ovf, 0);
    run_period(250, 100, -1, 0, -1, -1, 1, 16'd100, 4'd1, 0, 0);

    // Long period saturates; clear held during saturation loses to the set.
    run_period(65600, 0, -1, 0, -1, 65560, 1, 16'd0, 4'd0, 0, 0);
    check("overflow_set_wins_over_clear", ovf, 1);
    run_period(250, 100, -1, 0, -1, -1, 1, 16'd100, 4'd1, 0, 0);
    check("overflow_sticky", ovf, 1);
    run_period(250, 100, -1, 0, -1, 10, 1, 16'd100, 4'd1, 0, 0);
    check("overflow_cleared", ovf, 0);

    // Asynchronous reset in the middle of a period.
    run_period(120, 100, -1, 0, -1, -1, 0, 16'd0, 4'd0, 0, 0);
    check("period_before_reset", per_o, 250);
    #2;
    rst_n = 1'b0;
    pwm   = 1'b0;
    #1;
    check("async_reset_period", per_o, 0);
    check("async_reset_high", hi_o, 0);
    check("async_reset_edges_valid", {edg_o, valid}, 0);
    check("async_reset_flags", {sh, sl, ovf}, 0);
    check("queue_empty_before_reset", sb.size(), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) tick();
    check("period_after_release", per_o, 0);

    run_period(250, 100, -1, 0, -1, -1, 1, 16'd100, 4'd1, 0, 0);
    run_period(250, 100, -1, 0, -1, -1, 1, 16'd100, 4'd1, 0, 0);
    run_period(10, 0, -1, 0, -1, -1, 0, 16'd0, 4'd0, 0, 0);
    repeat (3) tick();
    check("all_reports_seen", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
